nibble_serial_adder_seq: RTL and testbench

Sequencer that adds or subtracts two multi-nibble operands using a single 4-bit carry-lookahead adder slice, time-shared over NIBBLES cycles. The carry out of each slice is registered and chained into the next nibble. It gives wide add/sub capability to lab datapaths without replicating adder hardware. A start/busy/done handshake sits in front of it.

---
 rtl/nibble_serial_adder_seq.sv | 158 +++++++++++++++
 tb/tb_nibble_serial_adder_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_seq.sv
// nibble_serial_adder_seq
// Wide add/subtract built from one 4-bit carry-lookahead slice. The slice is
// reused once per nibble. The slice carry is registered between nibbles, so an
// operation of W = 4*NIBBLES bits takes NIBBLES cycles in RUN. Subtraction is
// done as A + ~B + 1: the operand is inverted when it is latched and the carry
// register is preset to 1.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_IDLE | waiting for i_start; operands latched on the accepting edge
//  S_RUN  | one nibble per cycle, r_idx selects the slice inputs
//  S_DONE | results valid, o_done pulses, always returns to S_IDLE

module nibble_serial_adder_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic                   i_sub,
   input  logic                   i_carry_in,
   input  logic [4*NIBBLES-1:0]   i_a,
   input  logic [4*NIBBLES-1:0]   i_b,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [4*NIBBLES-1:0]   o_result,
   output logic                   o_carry_out,
   output logic                   o_overflow
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [W-1:0]    r_op_a;
   logic [W-1:0]    r_op_b;
   logic [W-1:0]    r_acc;
   logic            r_c;
   logic [IW-1:0]   r_idx;
   logic            r_busy;
   logic            r_done;
   logic [W-1:0]    r_result;
   logic            r_carry_out;
   logic            r_overflow;

   logic [3:0]      w_a_nib;
   logic [3:0]      w_b_nib;
   logic [3:0]      w_p;
   logic [3:0]      w_g;
   logic [3:0]      w_cy;
   logic            w_cout;
   logic [3:0]      w_sum_nib;
   logic [W-1:0]    w_acc_next;
   logic            w_last;
   logic            w_overflow;

   // Slice operand select, carry-lookahead slice and accumulator merge.
   always_comb begin
      w_a_nib    = '0;
      w_b_nib    = '0;
      w_acc_next = r_acc;
      for (int n = 0; n < NIBBLES; n++) begin
         if (r_idx == IW'(n)) begin
            w_a_nib = r_op_a[4*n +: 4];
            w_b_nib = r_op_b[4*n +: 4];
         end
      end

      w_p     = w_a_nib ^ w_b_nib;
      w_g     = w_a_nib & w_b_nib;
      w_cy[0] = r_c;
      w_cy[1] = w_g[0] | (w_p[0] & r_c);
      w_cy[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_c);
      w_cy[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & r_c);
      w_cout  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_c);
      w_sum_nib = w_p ^ w_cy;

      for (int m = 0; m < NIBBLES; m++) begin
         if (r_idx == IW'(m)) begin
            w_acc_next[4*m +: 4] = w_sum_nib;
         end
      end
   end

   assign w_last     = (r_idx == IW'(NIBBLES - 1));
   // Operand B is already inverted for subtraction, so one rule covers both.
   assign w_overflow = (r_op_a[W-1] == r_op_b[W-1]) && (w_acc_next[W-1] != r_op_a[W-1]);

   // Sequencer: accept, step one nibble per cycle, publish results on exit.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_acc       <= '0;
         r_c         <= 1'b0;
         r_idx       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_op_a  <= i_a;
                  r_op_b  <= i_sub ? ~i_b : i_b;
                  r_c     <= i_sub ? 1'b1 : i_carry_in;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc <= w_acc_next;
               r_c   <= w_cout;
               r_idx <= r_idx + IW'(1);
               if (w_last) begin
                  r_result    <= w_acc_next;
                  r_carry_out <= w_cout;
                  r_overflow  <= w_overflow;
                  r_idx       <= '0;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_result    = r_result;
   assign o_carry_out = r_carry_out;
   assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_nibble_serial_adder_seq.sv
// Bench for nibble_serial_adder_seq: a 16-bit instance checked every cycle
// against an arithmetic model, plus directed literal checks, and an 8-bit
// instance for the NIBBLES=2 boundary.
module tb_nibble_serial_adder_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sub = 1'b0;
   logic        cin = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy, done, co, ov;
   logic [15:0] res;

   logic        start2 = 1'b0;
   logic [7:0]  a2 = '0;
   logic [7:0]  b2 = '0;
   logic        busy2, done2, co2, ov2;
   logic [7:0]  res2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nibble_serial_adder_seq #(.NIBBLES(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sub(sub),
      .i_carry_in(cin), .i_a(a), .i_b(b), .o_busy(busy), .o_done(done),
      .o_result(res), .o_carry_out(co), .o_overflow(ov));

   nibble_serial_adder_seq #(.NIBBLES(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_sub(sub),
      .i_carry_in(cin), .i_a(a2), .i_b(b2), .o_busy(busy2), .o_done(done2),
      .o_result(res2), .o_carry_out(co2), .o_overflow(ov2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: an accepted request reports A +/- B exactly four cycles later,
   // then spends one cycle in done before it listens to start again.
   logic        m_busy = 0, m_done = 0, m_co = 0, m_ov = 0;
   logic [15:0] m_res = '0;
   logic        p_co = 0, p_ov = 0;
   logic [15:0] p_res = '0;
   int          m_left = 0;

   always @(posedge clk or negedge rst_n) begin
      logic [15:0] opb;
      logic [16:0] full;
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_res = '0; m_co = 0; m_ov = 0; m_left = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 0; m_done = 1;
            m_res = p_res; m_co = p_co; m_ov = p_ov;
         end
      end else if (start) begin
         opb   = sub ? ~b : b;
         full  = {1'b0, a} + {1'b0, opb} + 17'(sub ? 1'b1 : cin);
         p_res = full[15:0];
         p_co  = full[16];
         p_ov  = (a[15] == opb[15]) && (p_res[15] != a[15]);
         m_busy = 1;
         m_left = 4;
      end
   end

   always @(negedge clk) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("result", res, m_res);
      chk("carry_out", co, m_co);
      chk("overflow", ov, m_ov);
      chk("busy_and_done", busy & done, 0);
   end

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic ts, input logic tc, input logic [15:0] er,
                         input logic eco, input logic eov, input string nm);
      int d;
      int bc;
      bit got;
      @(negedge clk);
      a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
      @(posedge clk);
      d = 0; bc = 0; got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (t == 0) begin
            start = 1'b0; a = ~ta; b = 16'h5A5A; sub = ~ts; cin = ~tc;
         end
         if (done) got = 1;
         else begin
            bc += int'(busy);
            d++;
         end
      end
      chk({nm, " done_seen"}, 32'(got), 1);
      chk({nm, " latency"}, d, 4);
      chk({nm, " busy_cycles"}, bc, 4);
      chk({nm, " result"}, res, er);
      chk({nm, " carry_out"}, co, eco);
      chk({nm, " overflow"}, ov, eov);
   endtask

   initial begin
      int ndone;
      int first_done;
      int second_done;
      int d2;
      bit got2;

      repeat (3) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset result", res, 0);
      chk("reset carry_out", co, 0);
      chk("reset overflow", ov, 0);
      rst_n = 1'b1;

      run_op(16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, "add_basic");
      run_op(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, "add_ripple");
      run_op(16'h0000, 16'h0000, 0, 1, 16'h0001, 0, 0, "add_cin");
      run_op(16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, "sub_borrow");
      run_op(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, "add_ovf");
      run_op(16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1, "sub_ovf");

      // Start held high through RUN with other operands: one result only.
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; sub = 0; cin = 0; start = 1'b1;
      @(posedge clk);
      ndone = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         a = 16'h9000 + 16'(t); b = 16'h0F00;
         if (t == 1) chk("hold prev_result", res, 16'h7FFF);
         if (done) begin
            ndone++;
            start = 1'b0;
            chk("hold result", res, 16'h3333);
         end
      end
      chk("hold done_count", ndone, 1);

      // Start held continuously: measure the gap between two done pulses.
      @(negedge clk);
      start = 1'b1; a = 16'h0100; b = 16'h0020;
      first_done = -1; second_done = -1;
      for (int t = 0; t < 24; t++) begin
         @(negedge clk);
         a = a + 16'h0123; b = b + 16'h0011;
         if (done) begin
            if (first_done < 0) first_done = t;
            else if (second_done < 0) second_done = t;
         end
      end
      start = 1'b0;
      chk("stream done_gap", second_done - first_done, 6);
      repeat (3) @(negedge clk);

      // Asynchronous reset two cycles into a run.
      @(negedge clk);
      a = 16'hAAAA; b = 16'h5555; sub = 0; cin = 0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort result", res, 0);
      chk("abort carry_out", co, 0);
      chk("abort overflow", ov, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("abort no_done", done, 0);
      end
      run_op(16'h0F0F, 16'h0101, 0, 0, 16'h1010, 0, 0, "after_reset");

      // Two-nibble instance.
      @(negedge clk);
      a2 = 8'hFF; b2 = 8'h01; sub = 0; cin = 0; start2 = 1'b1;
      @(posedge clk);
      d2 = 0; got2 = 0;
      for (int t = 0; t < 10 && !got2; t++) begin
         @(negedge clk);
         if (t == 0) begin
            start2 = 1'b0; a2 = 8'h00; b2 = 8'h00;
         end
         if (done2) got2 = 1;
         else d2++;
      end
      chk("n2 done_seen", 32'(got2), 1);
      chk("n2 latency", d2, 2);
      chk("n2 result", res2, 8'h00);
      chk("n2 carry_out", co2, 1);
      chk("n2 overflow", ov2, 0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
